// File: rtl/imem_loader.sv
// imem_loader: writer side of the instruction memory.
//
// Takes a program image as a byte stream over a valid/ready handshake. The
// image is a 16-bit big-endian word count N followed by 4*N payload bytes. The
// payload bytes are packed MSB-first into 32-bit words. Each word goes to the
// instruction store as a one-cycle write strobe at a word-aligned byte address,
// starting at BASE_ADDR.
//
// Optional build macro: IMEM_LOADER_CHECKSUM_EN
//   When it is defined, one trailing byte follows the payload. That byte must
//   equal the XOR of all payload bytes, or the load ends in the error state.
//
// Parameters:
//   DEPTH      number of 32-bit words in the instruction store (max image size)
//   BASE_ADDR  byte address of the first word written (multiple of 4)
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       single-cycle load request (honoured in IDLE, DONE, ERR only)
//   byte_in     stream data byte
//   byte_valid  byte_in valid this cycle
//   byte_ready  loader accepts a byte this cycle (function of state only)
//   im_we       instruction memory write strobe, one cycle per word
//   im_addr     byte address of the word being written
//   im_wdata    word being written
//   busy        load in progress
//   done        image loaded successfully (level)
//   err         image rejected (level)
//   word_count  words written in the current load
module imem_loader #(
    parameter int unsigned DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        im_we,
    output logic [31:0] im_addr,
    output logic [31:0] im_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] word_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_HI,
        S_HDR_LO,
        S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE,
        S_ERR
    } state_t;

    state_t      state;
    logic [7:0]  n_hi;       // upper header byte, held until the low byte arrives
    logic [15:0] n_words;    // image length in words
    logic [1:0]  lane;       // byte position within the current word
    logic [23:0] word_buf;   // first three bytes of the word being assembled
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  csum;       // running XOR of the payload bytes
`endif

    logic        xfer;
    logic [15:0] n_hdr;
    logic        last_word;

    always_comb begin
        byte_ready = 1'b0;
        unique case (state)
            S_HDR_HI, S_HDR_LO, S_DATA: byte_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM:                     byte_ready = 1'b1;
`endif
            default:                    byte_ready = 1'b0;
        endcase
    end

    assign xfer      = byte_valid & byte_ready;
    assign n_hdr     = {n_hi, byte_in};
    assign last_word = ((word_count + 16'd1) == n_words);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            n_hi       <= '0;
            n_words    <= '0;
            lane       <= '0;
            word_buf   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
            im_we      <= 1'b0;
            im_addr    <= BASE_ADDR;
            im_wdata   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            word_count <= '0;
        end else begin
            im_we <= 1'b0;
            unique case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state      <= S_HDR_HI;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        err        <= 1'b0;
                        word_count <= '0;
                        lane       <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum       <= '0;
`endif
                    end
                end

                S_HDR_HI: begin
                    if (xfer) begin
                        n_hi  <= byte_in;
                        state <= S_HDR_LO;
                    end
                end

                S_HDR_LO: begin
                    if (xfer) begin
                        n_words <= n_hdr;
                        if ({16'h0000, n_hdr} > DEPTH) begin
                            state <= S_ERR;
                            busy  <= 1'b0;
                            err   <= 1'b1;
                        end else if (n_hdr == 16'h0000) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state <= S_CSUM;
`else
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
`endif
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum <= csum ^ byte_in;
`endif
                        lane <= lane + 2'd1;
                        if (lane == 2'd3) begin
                            // Lane 0 has been shifted up to [31:24] by now.
                            im_we      <= 1'b1;
                            im_wdata   <= {word_buf, byte_in};
                            im_addr    <= BASE_ADDR + {14'b0, word_count, 2'b00};
                            word_count <= word_count + 16'd1;
                            if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                state <= S_CSUM;
`else
                                state <= S_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
`endif
                            end
                        end else begin
                            word_buf <= {word_buf[15:0], byte_in};
                        end
                    end
                end

`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (xfer) begin
                        busy <= 1'b0;
                        if (byte_in == csum) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_ERR;
                            err   <= 1'b1;
                        end
                    end
                end
`endif

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    localparam int unsigned DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  byte_in = '0;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic        im_we;
    logic [31:0] im_addr;
    logic [31:0] im_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] word_count;

    imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .im_we      (im_we),
        .im_addr    (im_addr),
        .im_wdata   (im_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          at_cyc;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        mon_e;
    int         wr_idx = 0;
    logic [7:0] xsum = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest expected write,
    // including the cycle in which it was predicted to appear.
    always @(negedge clk) begin
        if (im_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_we", 32'(im_addr), 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check("we_addr", im_addr, mon_e.addr);
                check("we_data", im_wdata, mon_e.data);
                check("we_cycle", 32'(cyc), 32'(mon_e.at_cyc));
            end
        end
    end

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        byte_in    = b;
        byte_valid = 1'b1;
        while (byte_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("ready_timeout", 32'(byte_ready), 32'd1);
        @(posedge clk);
    endtask

    task automatic gap(input int n);
        @(negedge clk);
        byte_valid = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input int stall);
        logic [7:0] b;
        for (int i = 0; i < 4; i++) begin
            if (stall > 0) gap(stall);
            b = w[31-8*i -: 8];
            send(b);
            xsum = xsum ^ b;
        end
        #1;
        exp_q.push_back('{addr: BASE + 32'(4 * wr_idx), data: w, at_cyc: cyc});
        wr_idx++;
    endtask

    task automatic start_load();
        @(negedge clk);
        byte_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        wr_idx = 0;
        xsum   = '0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_wc", 32'(word_count), 32'd0);
        check("start_done", 32'(done), 32'd0);
    endtask

    task automatic send_header(input logic [15:0] n, input int stall);
        send(n[15:8]);
        if (stall > 0) gap(stall);
        send(n[7:0]);
    endtask

    task automatic end_checksum(input int stall);
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (stall > 0) gap(stall);
        send(xsum);
`else
        if (stall > 0) gap(0);
`endif
    endtask

    task automatic expect_done(input string tag, input int nw);
        @(negedge clk);
        byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_wc"}, 32'(word_count), 32'(nw));
        check({tag, "_ready"}, 32'(byte_ready), 32'd0);
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, 32'(byte_ready), 32'd0);
        check({tag, "_we"}, 32'(im_we), 32'd0);
        check({tag, "_addr"}, im_addr, BASE);
        check({tag, "_wdata"}, im_wdata, 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_wc"}, 32'(word_count), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready", 32'(byte_ready), 32'd0);

        // Basic load, back-to-back bytes
        start_load();
        send_header(16'd2, 0);
        send_word(32'h8C01_0004, 0);
        send_word(32'h8C0C_000C, 0);
        end_checksum(0);
        expect_done("basic", 2);

        // Same image with three idle cycles between every byte
        start_load();
        send_header(16'd2, 3);
        send_word(32'h8C01_0004, 3);
        send_word(32'h8C0C_000C, 3);
        end_checksum(3);
        expect_done("stall", 2);

        // Oversize header: rejected after the second header byte
        start_load();
        send_header(16'h0101, 0);
        #1;
        check("over_err", 32'(err), 32'd1);
        check("over_busy", 32'(busy), 32'd0);
        check("over_ready", 32'(byte_ready), 32'd0);
        byte_in = 8'hA5;
        repeat (4) @(negedge clk);
        byte_valid = 1'b0;
        check("over_err_hold", 32'(err), 32'd1);
        check("over_wc", 32'(word_count), 32'd0);
        check("over_done", 32'(done), 32'd0);

        // Zero-length image
        start_load();
        check("restart_err_clr", 32'(err), 32'd0);
        send_header(16'd0, 0);
        end_checksum(0);
        expect_done("zero", 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Zero-length image with a wrong trailing byte
        start_load();
        send_header(16'd0, 0);
        send(8'h5A);
        @(negedge clk);
        byte_valid = 1'b0;
        @(negedge clk);
        check("zero_bad_err", 32'(err), 32'd1);
        check("zero_bad_done", 32'(done), 32'd0);
        check("zero_bad_busy", 32'(busy), 32'd0);
`endif

        // Reset two bytes into the second word
        start_load();
        send_header(16'd2, 0);
        send_word(32'h8C01_0004, 0);
        send(8'h8C);
        send(8'h0C);
        @(negedge clk);
        byte_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        repeat (3) @(negedge clk);
        check("midrst_pending", 32'(exp_q.size()), 32'd0);
        rst_n = 1'b1;

        // Full load after the reset starts again at BASE
        start_load();
        send_header(16'd2, 0);
        send_word(32'h1234_5678, 0);
        send_word(32'h9ABC_DEF0, 0);
        end_checksum(0);
        expect_done("postrst", 2);

        // start pulsed mid-payload is ignored
        start_load();
        send_header(16'd2, 0);
        send_word(32'hDEAD_BEEF, 0);
        @(negedge clk);
        byte_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ign_busy", 32'(busy), 32'd1);
        check("ign_wc", 32'(word_count), 32'd1);
        check("ign_ready", 32'(byte_ready), 32'd1);
        send_word(32'h0BAD_F00D, 0);
        end_checksum(0);
        expect_done("ignore", 2);

        // New load after done writes address BASE again
        start_load();
        send_header(16'd1, 0);
        send_word(32'h2108_0001, 0);
        end_checksum(0);
        expect_done("reload", 1);

        repeat (3) @(negedge clk);
        check("final_pending", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
